rom_arbiter: RTL and testbench

//  Shares one synchronous-read ROM (1-cycle registered read, 14-bit address, 8-bit data)

---
 rtl/rom_arbiter.sv | 156 +++++++++++++++
 tb/tb_rom_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/rom_arbiter.sv
// -----------------------------------------------------------------------------
// rom_arbiter
//
// Shares one synchronous-read ROM (registered read, one clock of latency)
// between two requesters. Each cycle at most one request is granted, either
// round-robin or with port 0 always winning. Every grant issues one ROM access,
// so a new access can start on every clock. Read data is returned to the port
// that issued the access, three clock edges after the accept.
//
// Ports
//   clk       in   1   system clock, rising edge
//   rst_n     in   1   synchronous reset, active low
//   req0      in   1   port 0 request, held with addr0 until accepted
//   addr0     in   AW  port 0 read address
//   gnt0      out  1   port 0 grant (combinational); accept = req0 & gnt0
//   dout0     out  DW  port 0 read data, held between strobes
//   valid0    out  1   one-cycle strobe: dout0 carries new data
//   req1 / addr1 / gnt1 / dout1 / valid1  same for port 1
//   rom_a     out  AW  registered ROM address
//   rom_dout  in   DW  ROM read data, valid one clock after rom_a
// -----------------------------------------------------------------------------
module rom_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 8,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req0,
    input  logic [AW-1:0] addr0,
    output logic          gnt0,
    output logic [DW-1:0] dout0,
    output logic          valid0,
    input  logic          req1,
    input  logic [AW-1:0] addr1,
    output logic          gnt1,
    output logic [DW-1:0] dout1,
    output logic          valid1,
    output logic [AW-1:0] rom_a,
    input  logic [DW-1:0] rom_dout
);

    // Port that wins the next tie (0 or 1).
    logic          r_rr;
    // Tag travelling alongside the access: stage 1 while the ROM address is
    // presented, stage 2 while the ROM produces data.
    logic          r_tag1_vld;
    logic          r_tag1_port;
    logic          r_tag2_vld;
    logic          r_tag2_port;
    logic [AW-1:0] r_rom_a;
    logic [DW-1:0] r_dout0;
    logic [DW-1:0] r_dout1;
    logic          r_valid0;
    logic          r_valid1;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_accept;
    logic          w_win_port;
    logic [AW-1:0] w_win_addr;

    // Grant selection: a lone request always wins; a tie is settled by the
    // fixed priority or by the round-robin pointer. No grant while in reset.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!rst_n) begin
            w_gnt0 = 1'b0;
            w_gnt1 = 1'b0;
        end else if (req0 && req1) begin
            if ((FIXED_PRIO != 32'sd0) || (r_rr == 1'b0)) begin
                w_gnt0 = 1'b1;
            end else begin
                w_gnt1 = 1'b1;
            end
        end else begin
            w_gnt0 = req0;
            w_gnt1 = req1;
        end
    end

    // Winner's identity and address; a grant is only ever given to a
    // requesting port, so any grant is an accept.
    always_comb begin
        w_accept   = w_gnt0 | w_gnt1;
        w_win_port = w_gnt1;
        if (w_gnt1) begin
            w_win_addr = addr1;
        end else begin
            w_win_addr = addr0;
        end
    end

    // Round-robin pointer: after an accept, the other port gets the next tie.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rr <= 1'b0;
        end else if (w_accept) begin
            r_rr <= ~w_win_port;
        end
    end

    // ROM address register: only loaded on an accept, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rom_a <= {AW{1'b0}};
        end else if (w_accept) begin
            r_rom_a <= w_win_addr;
        end
    end

    // Two-stage tag shift register; idle cycles shift in an invalid tag and
    // reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_tag1_vld  <= 1'b0;
            r_tag1_port <= 1'b0;
            r_tag2_vld  <= 1'b0;
            r_tag2_port <= 1'b0;
        end else begin
            r_tag1_vld  <= w_accept;
            r_tag1_port <= w_win_port;
            r_tag2_vld  <= r_tag1_vld;
            r_tag2_port <= r_tag1_port;
        end
    end

    // Return stage: steer ROM data to the owning port and strobe its valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dout0  <= {DW{1'b0}};
            r_dout1  <= {DW{1'b0}};
            r_valid0 <= 1'b0;
            r_valid1 <= 1'b0;
        end else begin
            r_valid0 <= r_tag2_vld & ~r_tag2_port;
            r_valid1 <= r_tag2_vld & r_tag2_port;
            if (r_tag2_vld && !r_tag2_port) begin
                r_dout0 <= rom_dout;
            end
            if (r_tag2_vld && r_tag2_port) begin
                r_dout1 <= rom_dout;
            end
        end
    end

    assign gnt0   = w_gnt0;
    assign gnt1   = w_gnt1;
    assign rom_a  = r_rom_a;
    assign dout0  = r_dout0;
    assign dout1  = r_dout1;
    assign valid0 = r_valid0;
    assign valid1 = r_valid1;

endmodule

// File: tb/tb_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rom_arbiter
//
// Two instances share the same stimulus: instance 0 round-robin, instance 1
// fixed priority. Each has its own ROM (mem[i] = i[7:0] ^ 8'hA5). A
// transaction-level model predicts grants and the read results per port;
// directed literal checks pin the model to hand-computed values.
// -----------------------------------------------------------------------------
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0;
    logic        req1;
    logic [13:0] addr0;
    logic [13:0] addr1;

    // Packed per-instance outputs: bit/slice 0 = round-robin, 1 = fixed prio.
    logic [1:0]  g0;
    logic [1:0]  g1;
    logic [1:0]  v0;
    logic [1:0]  v1;
    logic [15:0] d0p;
    logic [15:0] d1p;
    logic [27:0] rap;
    logic [7:0]  rd_a;
    logic [7:0]  rd_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.AW(14), .DW(8), .FIXED_PRIO(0)) dut_rr (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(g0[0]), .dout0(d0p[7:0]), .valid0(v0[0]),
        .req1(req1), .addr1(addr1), .gnt1(g1[0]), .dout1(d1p[7:0]), .valid1(v1[0]),
        .rom_a(rap[13:0]), .rom_dout(rd_a)
    );

    rom_arbiter #(.AW(14), .DW(8), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .gnt0(g0[1]), .dout0(d0p[15:8]), .valid0(v0[1]),
        .req1(req1), .addr1(addr1), .gnt1(g1[1]), .dout1(d1p[15:8]), .valid1(v1[1]),
        .rom_a(rap[27:14]), .rom_dout(rd_b)
    );

    // ROM models: registered read of mem[a] = a[7:0] ^ A5.
    always @(posedge clk) rd_a <= rap[7:0] ^ 8'hA5;
    always @(posedge clk) rd_b <= rap[21:14] ^ 8'hA5;

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         ecnt = 0;
    bit         m_rr [2];
    bit         sv [2][4];          // result scheduled for edge slot
    bit         sp [2][4];          // owning port
    logic [7:0] sd [2][4];          // data = mem[addr]
    logic [1:0] ev [2]  = '{default: 2'b00};
    logic [7:0] ed0 [2] = '{default: 8'h00};
    logic [7:0] ed1 [2] = '{default: 8'h00};

    function automatic logic [1:0] exp_gnt(input int inst, input logic rn,
                                           input logic r0, input logic r1, input bit rr);
        if (!rn) return 2'b00;
        if (r0 && r1) return ((inst == 1) || !rr) ? 2'b01 : 2'b10;
        return {r1, r0};
    endfunction

    // Model update on each edge: deliver what is due now, schedule new reads
    // two edges later (visible in the cycle after that edge).
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int         s;
            logic [1:0] g;
            s = ecnt % 4;
            if (!rst_n) begin
                for (int k = 0; k < 4; k++) sv[i][k] = 1'b0;
                m_rr[i] = 1'b0;
                ev[i]   = 2'b00;
                ed0[i]  = 8'h00;
                ed1[i]  = 8'h00;
            end else begin
                ev[i] = 2'b00;
                if (sv[i][s]) begin
                    if (sp[i][s]) begin ev[i][1] = 1'b1; ed1[i] = sd[i][s]; end
                    else          begin ev[i][0] = 1'b1; ed0[i] = sd[i][s]; end
                    sv[i][s] = 1'b0;
                end
                g = exp_gnt(i, rst_n, req0, req1, m_rr[i]);
                if (g != 2'b00) begin
                    sv[i][(ecnt + 2) % 4] = 1'b1;
                    sp[i][(ecnt + 2) % 4] = g[1];
                    sd[i][(ecnt + 2) % 4] = (g[1] ? addr1[7:0] : addr0[7:0]) ^ 8'hA5;
                    m_rr[i] = ~g[1];
                end
            end
        end
        ecnt++;
    end

    // Compare every cycle, mid-period.
    always @(negedge clk) begin
        if (ecnt > 0) begin
            for (int i = 0; i < 2; i++) begin
                logic [1:0] eg;
                eg = exp_gnt(i, rst_n, req0, req1, m_rr[i]);
                chk($sformatf("m_gnt0[%0d]", i),   {15'd0, g0[i]}, {15'd0, eg[0]});
                chk($sformatf("m_gnt1[%0d]", i),   {15'd0, g1[i]}, {15'd0, eg[1]});
                chk($sformatf("m_valid0[%0d]", i), {15'd0, v0[i]}, {15'd0, ev[i][0]});
                chk($sformatf("m_valid1[%0d]", i), {15'd0, v1[i]}, {15'd0, ev[i][1]});
                chk($sformatf("m_dout0[%0d]", i),  {8'd0, d0p[8*i +: 8]}, {8'd0, ed0[i]});
                chk($sformatf("m_dout1[%0d]", i),  {8'd0, d1p[8*i +: 8]}, {8'd0, ed1[i]});
            end
        end
    end

    task automatic nextc();
        @(posedge clk);
        #2;
    endtask

    // ---------------- directed stimulus + literal checks ----------------
    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        addr0 = 14'h0010; addr1 = 14'h0020;

        // Reset with both requesting.
        repeat (3) begin
            @(negedge clk);
            chk("t1_gnt", {12'd0, g1, g0}, 16'h0000);
            chk("t1_valid", {12'd0, v1, v0}, 16'h0000);
            chk("t1_rom_a", rap[15:0], 16'h0000);
        end
        nextc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t1_first_gnt0_rr", {15'd0, g0[0]}, 16'h0001);
        chk("t1_first_gnt0_fp", {15'd0, g0[1]}, 16'h0001);

        // Both requesting continuously.
        for (int k = 1; k <= 8; k++) begin
            nextc();
            @(negedge clk);
            chk("t4_fp_gnt1", {15'd0, g1[1]}, 16'h0000);
            if (k >= 3) begin
                chk("t3_rr_alt", {15'd0, v0[0] ^ v1[0]}, 16'h0001);
                chk("t4_fp_valid0", {15'd0, v0[1]}, 16'h0001);
            end
        end
        chk("t3_rr_dout0", {8'd0, d0p[7:0]}, 16'h00B5);
        chk("t3_rr_dout1", {8'd0, d1p[7:0]}, 16'h0085);

        // Drop req0: port 1 wins on fixed priority in the same cycle.
        nextc();
        req0 = 1'b0;
        @(negedge clk);
        chk("t4_fp_gnt1_drop", {15'd0, g1[1]}, 16'h0001);
        nextc();
        req1 = 1'b0;
        nextc();
        nextc();
        @(negedge clk);
        chk("t4_fp_valid1", {15'd0, v1[1]}, 16'h0001);
        chk("t4_fp_dout1", {8'd0, d1p[15:8]}, 16'h0085);

        // Single read.
        repeat (3) nextc();
        req0 = 1'b1; addr0 = 14'h0005;
        @(negedge clk);
        chk("t2_gnt0", {14'd0, g0}, 16'h0003);
        nextc();
        req0 = 1'b0;
        @(negedge clk);
        chk("t2_rom_a_rr", {2'd0, rap[13:0]}, 16'h0005);
        chk("t2_rom_a_fp", {2'd0, rap[27:14]}, 16'h0005);
        nextc();
        nextc();
        @(negedge clk);
        chk("t2_valid0", {14'd0, v0}, 16'h0003);
        chk("t2_dout0", d0p, 16'hA0A0);

        // Reset while a read is in flight.
        nextc();
        nextc();
        req1 = 1'b1; addr1 = 14'h0001;
        nextc();
        rst_n = 1'b0; req1 = 1'b0;
        nextc();
        rst_n = 1'b1;
        repeat (5) begin
            nextc();
            @(negedge clk);
            chk("t5_no_valid1", {14'd0, v1}, 16'h0000);
        end
        chk("t5_dout1", d1p, 16'h0000);

        // Streaming through the address wrap on port 1.
        nextc();
        req1 = 1'b1; addr1 = 14'h3FFE;
        nextc();
        addr1 = 14'h3FFF;
        nextc();
        addr1 = 14'h0000;
        nextc();
        req1 = 1'b0;
        @(negedge clk);
        chk("t6_valid1_a", {14'd0, v1}, 16'h0003);
        chk("t6_dout1_a", d1p, 16'h5B5B);
        nextc();
        @(negedge clk);
        chk("t6_valid1_b", {14'd0, v1}, 16'h0003);
        chk("t6_dout1_b", d1p, 16'h5A5A);
        nextc();
        @(negedge clk);
        chk("t6_valid1_c", {14'd0, v1}, 16'h0003);
        chk("t6_dout1_c", d1p, 16'hA5A5);

        repeat (4) nextc();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
